// File: rtl/demux_pkt_pkg.sv
// Shared types and helpers for the packet demultiplexer.
// Optional per-channel statistics are enabled with DEMUX_PKT_STATS_EN.
package demux_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 16;

  // LSB position of channel ch inside a flattened per-channel bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding register with valid/ready on the output side.
// A write while the slot drains replaces the beat, so one beat per cycle streams through.
module demux_out_slot #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          slot_free,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          last_q;

  assign slot_free = !valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      data_q  <= wr_data;
      last_q  <= wr_last;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/demux_1xn_pkt.sv
// Registered 1-to-N packet demultiplexer; the header beat selects the channel for the whole packet.
// Define DEMUX_PKT_STATS_EN to add per-channel packet counters and a drop counter.
module demux_1xn_pkt
  import demux_pkt_pkg::*;
#(
  parameter  int unsigned N_CH = 8,
  parameter  int unsigned DW   = 8,
  localparam int unsigned SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               in_last,
  input  logic [SELW-1:0]    in_sel,
  output logic [N_CH-1:0]    out_valid,
  input  logic [N_CH-1:0]    out_ready,
  output logic [N_CH*DW-1:0] out_data,
  output logic [N_CH-1:0]    out_last,
`ifdef DEMUX_PKT_STATS_EN
  input  logic                  stats_clr,
  output logic [N_CH*CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
`endif
  output logic               err_sel
);

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic              err_q, err_d;
  logic [SELW-1:0]   tgt;
  logic              sel_ok, free_tgt, accept, fwd;
  logic [N_CH-1:0]   slot_free, wr_en;

  always_comb begin
    sel_ok   = 32'(in_sel) < N_CH;
    tgt      = (state_q == IDLE) ? in_sel : lock_ch_q;
    free_tgt = 1'b0;
    // Compare rather than index so an out-of-range select never reads past the slot array.
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(tgt) == k) free_tgt = slot_free[k];
    end
    in_ready = (state_q == DROP) | ((state_q == IDLE) & !sel_ok) | free_tgt;
    accept   = in_valid & in_ready;
    fwd      = accept & ((state_q == LOCK) | ((state_q == IDLE) & sel_ok));
    wr_en    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      wr_en[k] = fwd & (32'(tgt) == k);
    end

    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    err_d     = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!sel_ok) begin
            err_d = 1'b1;
            if (!in_last) state_d = DROP;
          end else if (!in_last) begin
            state_d   = LOCK;
            lock_ch_d = in_sel;
          end
        end
        LOCK, DROP: if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      err_q     <= err_d;
    end
  end

  assign err_sel = err_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_out_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[k]),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .slot_free (slot_free[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[ch_lsb(k, DW) +: DW]),
      .out_last  (out_last[k])
    );
  end

`ifdef DEMUX_PKT_STATS_EN
  logic [N_CH*CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0]      drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (stats_clr) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (out_valid[k] && out_ready[k] && out_last[k] &&
            pkt_cnt_q[ch_lsb(k, CNT_W) +: CNT_W] != '1)
          pkt_cnt_q[ch_lsb(k, CNT_W) +: CNT_W] <=
            pkt_cnt_q[ch_lsb(k, CNT_W) +: CNT_W] + CNT_W'(1);
      end
      if (err_q && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1xn_pkt.sv
// Bench for demux_1xn_pkt with N_CH=6; a queue-per-channel model checks every cycle.
// Statistics checks are compiled in when DEMUX_PKT_STATS_EN is defined.
module tb_demux_1xn_pkt;

  localparam int NCH = 6;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic [2:0]        in_sel = '0;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready = '1;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_last;
  logic              err_sel;
`ifdef DEMUX_PKT_STATS_EN
  logic              stats_clr = 1'b0;
  logic [NCH*16-1:0] pkt_cnt;
  logic [15:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  demux_1xn_pkt #(.N_CH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef DEMUX_PKT_STATS_EN
    .stats_clr (stats_clr),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .err_sel   (err_sel)
  );

  int checks = 0;
  int errors = 0;

  // Model: each channel is a queue of {last,data} holding at most one beat.
  logic [DW:0] mq [NCH][$];
  int  mode;      // 0 awaiting header, 1 forwarding, 2 discarding
  int  lch;
  bit  err_pend;
  int  pc [NCH];
  int  dc;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mq[k].delete();
      pc[k] = 0;
    end
    mode = 0; lch = 0; err_pend = 0; dc = 0;
  endtask

  // Checks current outputs against the model at the falling edge, then advances one clock.
  task automatic cyc();
    logic [NCH-1:0]    ev, el;
    logic [NCH*DW-1:0] ed, dm;
    bit ok, er, acc, nerr;
    int t;
    @(negedge clk);
    ev = '0; el = '0; ed = '0; dm = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mq[k].size() > 0) begin
        ev[k] = 1'b1;
        el[k] = mq[k][0][DW];
        ed[k*DW +: DW] = mq[k][0][DW-1:0];
        dm[k*DW +: DW] = '1;
      end
    end
    ok = (int'(in_sel) < NCH);
    t  = (mode == 0) ? int'(in_sel) : lch;
    if (mode == 2) er = 1;
    else if (mode == 0 && !ok) er = 1;
    else er = (mq[t].size() == 0) || out_ready[t];
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data & dm), 64'(ed));
    chk("out_last", 64'(out_last & ev), 64'(el));
    chk("err_sel", 64'(err_sel), 64'(err_pend));
`ifdef DEMUX_PKT_STATS_EN
    for (int k = 0; k < NCH; k++) chk("pkt_cnt", 64'(pkt_cnt[k*16 +: 16]), 64'(pc[k]));
    chk("drop_cnt", 64'(drop_cnt), 64'(dc));
    if (stats_clr) begin
      for (int k = 0; k < NCH; k++) pc[k] = 0;
      dc = 0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (ev[k] && out_ready[k] && el[k] && pc[k] < 65535) pc[k]++;
      if (err_pend && dc < 65535) dc++;
    end
`endif
    acc = in_valid && er;
    for (int k = 0; k < NCH; k++)
      if (mq[k].size() > 0 && out_ready[k]) void'(mq[k].pop_front());
    nerr = 0;
    if (acc) begin
      case (mode)
        0: if (ok) begin
             mq[t].push_back({in_last, in_data});
             if (!in_last) begin mode = 1; lch = t; end
           end else begin
             nerr = 1;
             if (!in_last) mode = 2;
           end
        1: begin
             mq[lch].push_back({in_last, in_data});
             if (in_last) mode = 0;
           end
        default: if (in_last) mode = 0;
      endcase
    end
    err_pend = nerr;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int sel, input int data, input bit last);
    in_valid = 1'b1; in_sel = 3'(sel); in_data = 8'(data); in_last = last;
  endtask

  typedef struct {
    logic [2:0]     sel;
    logic [DW-1:0]  data;
    logic [NCH-1:0] ev;
    logic           err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    model_reset();
    for (int i = 0; i < 6; i++) tbl[i] = '{3'(i), 8'(8'hA0 + i), 6'(1 << i), 1'b0};
    tbl[6] = '{3'd6, 8'hA6, 6'b0, 1'b1};
    tbl[7] = '{3'd7, 8'hA7, 6'b0, 1'b1};
    tbl[8] = '{3'd1, 8'hB1, 6'b000010, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_err", 64'(err_sel), 64'(0));

    // Back-to-back single-beat packets, including invalid selects and recovery.
    for (int i = 0; i < 9; i++) begin
      beat(int'(tbl[i].sel), int'(tbl[i].data), 1'b1);
      cyc();
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
      chk("tbl_err", 64'(err_sel), 64'(tbl[i].err));
      if (tbl[i].ev != '0) begin
        chk("tbl_data", 64'(out_data[int'(tbl[i].sel)*DW +: DW]), 64'(tbl[i].data));
        chk("tbl_last", 64'(out_last[int'(tbl[i].sel)]), 64'(1));
      end
    end
    in_valid = 1'b0;
    cyc();

    // Select is locked after the header even though in_sel changes.
    for (int i = 0; i < 4; i++) begin
      beat((i == 0) ? 3 : 5, 8'h30 + i, i == 3);
      cyc();
      chk("lock_valid", 64'(out_valid), 64'(6'b001000));
      chk("lock_data", 64'(out_data[3*DW +: DW]), 64'(8'h30 + i));
      chk("lock_last", 64'(out_last[3]), 64'(i == 3));
    end
    in_valid = 1'b0;
    cyc();
    chk("lock_idle", 64'(out_valid), 64'(0));

    // Stalled channel 2 holds its beat; channel 4 flows once the packet completes.
    out_ready = 6'b111011;
    beat(2, 8'h21, 1'b0);
    cyc();
    beat(2, 8'h22, 1'b1);
    #1 chk("bp_stall_ready", 64'(in_ready), 64'(0));
    repeat (3) cyc();
    chk("bp_hold_data", 64'(out_data[2*DW +: DW]), 64'(8'h21));
    out_ready = '1;
    cyc();
    chk("bp_beat2", 64'(out_data[2*DW +: DW]), 64'(8'h22));
    chk("bp_beat2_last", 64'(out_last[2]), 64'(1));
    beat(4, 8'h41, 1'b0);
    cyc();
    beat(4, 8'h42, 1'b1);
    cyc();
    chk("bp_ch4", 64'(out_data[4*DW +: DW]), 64'(8'h42));
    in_valid = 1'b0;
    cyc();

    // Three-beat packet to an invalid channel is swallowed with one error pulse.
    for (int i = 0; i < 3; i++) begin
      beat(7, 8'hE0 + i, i == 2);
      #1 chk("inv_ready", 64'(in_ready), 64'(1));
      cyc();
      chk("inv_err", 64'(err_sel), 64'(i == 0));
      chk("inv_valid", 64'(out_valid), 64'(0));
    end
    beat(1, 8'h55, 1'b1);
    cyc();
    chk("inv_recover", 64'(out_valid), 64'(6'b000010));
    in_valid = 1'b0;
    cyc();

`ifdef DEMUX_PKT_STATS_EN
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin beat(1, i, 1'b1); cyc(); end
    beat(6, 0, 1'b0); cyc();
    beat(6, 0, 1'b1); cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("stats_pkt1", 64'(pkt_cnt[16 +: 16]), 64'(3));
    chk("stats_drop", 64'(drop_cnt), 64'(1));
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    chk("stats_clr_pkt", 64'(pkt_cnt), 64'(0));
    chk("stats_clr_drop", 64'(drop_cnt), 64'(0));
`endif

    // Random traffic with random back-pressure.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom);
      in_last   = ($urandom % 3) == 0;
      out_ready = 6'($urandom) | 6'($urandom);
`ifdef DEMUX_PKT_STATS_EN
      stats_clr = ($urandom % 50) == 0;
`endif
      cyc();
    end

    // Asynchronous reset mid-traffic, observed before any clock edge.
    in_valid = 1'b1; in_sel = 3'd2; out_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_err", 64'(err_sel), 64'(0));
    chk("async_rst_ready", 64'(in_ready), 64'(1));
    model_reset();
    in_valid = 1'b0;
`ifdef DEMUX_PKT_STATS_EN
    stats_clr = 1'b0;
    chk("async_rst_drop", 64'(drop_cnt), 64'(0));
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = '1;
    beat(0, 8'h99, 1'b1);
    cyc();
    chk("post_rst_data", 64'(out_data[0 +: DW]), 64'(8'h99));
    in_valid = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
